// File: rtl/lsu_pkg.sv
// Shared encodings for the sub-word load/store unit: access sizes, FSM states, lane widths.
// Used by lsu_subword and lsu_lane_mux (optional feature macro: LSU_ALIGN_CHECK_EN).
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int LANE_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WSTORE,
        RMW_RD,
        RMW_WR,
        ERR
    } state_t;

endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational lane logic: extracts and extends a byte/half for loads, and
// merges a byte/half of store data into a memory word for read-modify-write.
module lsu_lane_mux
    import lsu_pkg::*;
#(
    parameter int M = 32
) (
    input  logic [M-1:0]      i_word,
    input  logic [1:0]        i_size,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_unsigned,
    input  logic [HALF_W-1:0] i_wdata,
    output logic [M-1:0]      o_load,
    output logic [M-1:0]      o_merge
);

    logic signed [BYTE_W-1:0] w_byte;
    logic signed [HALF_W-1:0] w_half;
    logic                     w_bsign;
    logic                     w_hsign;

    always_comb begin
        w_byte  = i_word[{i_lane, 3'b000} +: BYTE_W];
        w_half  = i_word[{i_lane[1], 4'b0000} +: HALF_W];
        w_bsign = w_byte[BYTE_W-1] & ~i_unsigned;
        w_hsign = w_half[HALF_W-1] & ~i_unsigned;
        o_load  = i_word;
        o_merge = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{(M-BYTE_W){w_bsign}}, w_byte};
                o_merge[{i_lane, 3'b000} +: BYTE_W] = i_wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                o_load = {{(M-HALF_W){w_hsign}}, w_half};
                o_merge[{i_lane[1], 4'b0000} +: HALF_W] = i_wdata;
            end
            // word and reserved size pass the memory word through untouched
            default: begin
                o_load  = i_word;
                o_merge = i_word;
            end
        endcase
    end

endmodule

// File: rtl/lsu_subword.sv
// Load/store unit in front of a word-addressed memory: sub-word loads with extension,
// sub-word stores via read-modify-write. Optional alignment/range check: LSU_ALIGN_CHECK_EN.
module lsu_subword
    import lsu_pkg::*;
#(
    parameter int M = 32,
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [M-1:0] req_addr,
    input  logic [M-1:0] req_wdata,
    output logic         resp_valid,
    output logic [M-1:0] resp_rdata,
    output logic         resp_err,
    output logic         mem_we,
    output logic [M-1:0] mem_addr,
    output logic [M-1:0] mem_wd,
    input  logic [M-1:0] mem_rd
);

    if (M != 32) begin : g_bad_m
        $error("lsu_subword: M must be 32");
    end
    if (N < 1 || N > M - 2) begin : g_bad_n
        $error("lsu_subword: N out of range");
    end

    state_t              r_state;
    logic                r_ready;
    logic                r_resp_valid;
    logic [M-1:0]        r_resp_rdata;
    logic                r_mem_we;
    logic [M-1:0]        r_mem_wd;
    logic [M-1:0]        r_addr;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [HALF_W-1:0]   r_wdata;
    logic [M-1:0]        w_load;
    logic [M-1:0]        w_merge;
    logic                w_accept;
    logic                w_reject;

    assign w_accept = req_valid && r_ready;

`ifdef LSU_ALIGN_CHECK_EN
    logic r_resp_err;

    always_comb begin
        w_reject = |req_addr[M-1:N+2];
        if (req_size == SZ_HALF && req_addr[0]) w_reject = 1'b1;
        if (req_size[1] && req_addr[1:0] != 2'b00) w_reject = 1'b1;
    end

    assign resp_err = r_resp_err;
`else
    assign w_reject = 1'b0;
    assign resp_err = 1'b0;
`endif

    lsu_lane_mux #(.M(M)) u_lane_mux (
        .i_word     (mem_rd),
        .i_size     (r_size),
        .i_lane     (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    // Control state: FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wd     <= '0;
            r_addr       <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            r_resp_err   <= 1'b0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            r_mem_we     <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
            r_resp_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_ready <= 1'b0;
                        if (w_reject) begin
                            r_state <= ERR;
                        end else if (!req_we) begin
                            r_state <= LOAD;
                        end else if (req_size[1]) begin
                            r_state  <= WSTORE;
                            r_mem_we <= 1'b1;
                            r_mem_wd <= req_wdata;
                        end else begin
                            r_state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    r_resp_rdata <= w_load;
                    r_resp_valid <= 1'b1;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                RMW_RD: begin
                    // the merged word is the merge register; it is written next cycle
                    r_mem_we <= 1'b1;
                    r_mem_wd <= w_merge;
                    r_state  <= RMW_WR;
                end
                WSTORE, RMW_WR: begin
                    r_resp_rdata <= '0;
                    r_resp_valid <= 1'b1;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                ERR: begin
                    r_resp_rdata <= '0;
                    r_resp_valid <= 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
                    r_resp_err   <= 1'b1;
`endif
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Request data capture on accept
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata[HALF_W-1:0];
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mem_we     = r_mem_we;
    assign mem_addr   = {r_addr[M-1:2], 2'b00};
    assign mem_wd     = r_mem_wd;

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a behavioural word memory; build with or
// without LSU_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module tb_lsu_subword;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];
    logic        tb_we;
    logic [5:0]  tb_idx;
    logic [31:0] tb_data;

    int n_cmp;
    int n_fail;

    lsu_subword #(.M(32), .N(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (tb_we) mem[tb_idx] <= tb_data;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        tb_we   = 1'b1;
        tb_idx  = idx;
        tb_data = data;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Issue one request starting #1 after an edge; return at #1 after the edge where resp_valid shows.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int wecnt, output int rdylow);
        bit got;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1; wecnt = 0; rdylow = 0; got = 0; rdata = 'x; err = 1'bx;
        for (int i = 0; i < 10 && !got; i++) begin
            if (mem_we) wecnt++;
            if (!req_ready) rdylow++;
            if (resp_valid) begin
                got   = 1;
                rdata = resp_rdata;
                err   = resp_err;
            end else begin
                @(posedge clk);
                #1 lat++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_timeout: observed no resp_valid expected pulse");
        end
    endtask

    int          lat;
    int          wecnt;
    int          rdylow;
    logic [31:0] rdata;
    logic        err;

    initial begin
        n_cmp = 0; n_fail = 0;
        tb_we = 0; tb_idx = '0; tb_data = '0;
        req_valid = 0; req_we = 0; req_size = 2'd0; req_unsigned = 0;
        req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        reset = 1'b0;

        preload(6'd0, 32'h80FF_7F01);
        preload(6'd1, 32'hCAFE_8001);
        preload(6'd2, 32'h1122_3344);
        preload(6'd3, 32'h0000_0000);
        preload(6'd4, 32'h5566_7788);

        // byte loads
        do_req(1'b0, 2'd0, 1'b0, 32'd1, 32'h0, lat, rdata, err, wecnt, rdylow);
        check("lb_a1_s", rdata, 32'h0000_007F);
        check("lb_latency", lat, 2);
        check("lb_no_we", wecnt, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'd2, 32'h0, lat, rdata, err, wecnt, rdylow);
        check("lb_a2_s", rdata, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd0, 1'b1, 32'd3, 32'h0, lat, rdata, err, wecnt, rdylow);
        check("lb_a3_u", rdata, 32'h0000_0080);
        do_req(1'b0, 2'd0, 1'b0, 32'd3, 32'h0, lat, rdata, err, wecnt, rdylow);
        check("lb_a3_s", rdata, 32'hFFFF_FF80);
        check("lb_err", {31'b0, err}, 32'd0);

        // halfword loads
        do_req(1'b0, 2'd1, 1'b0, 32'd4, 32'h0, lat, rdata, err, wecnt, rdylow);
        check("lh_a4_s", rdata, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b1, 32'd6, 32'h0, lat, rdata, err, wecnt, rdylow);
        check("lh_a6_u", rdata, 32'h0000_CAFE);

        // byte store via read-modify-write
        do_req(1'b1, 2'd0, 1'b0, 32'd9, 32'h0000_00AB, lat, rdata, err, wecnt, rdylow);
        check("sb_latency", lat, 3);
        check("sb_we_cycles", wecnt, 1);
        check("sb_ready_low", rdylow, 2);
        check("sb_rdata_zero", rdata, 32'h0);
        check("sb_mem2", mem[2], 32'h1122_AB44);

        // half store into upper lane, then reserved-size load of the whole word
        do_req(1'b1, 2'd1, 1'b0, 32'd10, 32'hFFFF_1234, lat, rdata, err, wecnt, rdylow);
        check("sh_mem2", mem[2], 32'h1234_AB44);
        do_req(1'b0, 2'd3, 1'b0, 32'd8, 32'h0, lat, rdata, err, wecnt, rdylow);
        check("lw_size3", rdata, 32'h1234_AB44);

        // word store then immediate load of same word
        do_req(1'b1, 2'd2, 1'b0, 32'd12, 32'hDEAD_BEEF, lat, rdata, err, wecnt, rdylow);
        check("sw_we_cycles", wecnt, 1);
        check("sw_ready_low", rdylow, 1);
        check("sw_latency", lat, 2);
        do_req(1'b0, 2'd2, 1'b0, 32'd12, 32'h0, lat, rdata, err, wecnt, rdylow);
        check("lw_after_sw", rdata, 32'hDEAD_BEEF);
        check("lw_ready_low", rdylow, 1);

        // reset during RMW_RD aborts the write
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'd16; req_wdata = 32'h0000_BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("abort_in_rmw_rd", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_we_0", {31'b0, mem_we}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("abort_we_1", {31'b0, mem_we}, 32'd0);
        check("abort_resp_valid_1", {31'b0, resp_valid}, 32'd0);
        check("abort_mem4", mem[4], 32'h5566_7788);

        // misaligned word store
        do_req(1'b1, 2'd2, 1'b0, 32'd14, 32'h0BAD_F00D, lat, rdata, err, wecnt, rdylow);
`ifdef LSU_ALIGN_CHECK_EN
        check("mis_err", {31'b0, err}, 32'd1);
        check("mis_no_we", wecnt, 0);
        check("mis_rdata", rdata, 32'h0);
        check("mis_mem3", mem[3], 32'h0000_0000);
`else
        check("mis_err", {31'b0, err}, 32'd0);
        check("mis_we", wecnt, 1);
        check("mis_mem3", mem[3], 32'h0BAD_F00D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit directly upstream of the word-addressed data memory (word index = addr[M-1:2], combinational read, write on posedge clk when we=1).
- Converts core requests for byte, halfword and word accesses into word-only memory operations:
  - Loads: lane extraction with sign/zero extension.
  - Sub-word stores: two-phase read-modify-write.
- Valid/ready handshake; the core stalls while ready=0.

Parameters:
- M, 32, data/address width (must be 32).
- N, 6, memory depth exponent (2**N words); used only for the address range check under the optional feature.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; transfer when valid&ready.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word).
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr  in  M  byte address.
- req_wdata  in  M  store data, right-justified.
- resp_valid  out  1  one-cycle pulse, load data valid / store complete.
- resp_rdata  out  M  extended load data (0 for stores).
- resp_err  out  1  with resp_valid: request was misaligned/out of range (feature only, else 0).
- mem_we  out  1  to memory we.
- mem_addr  out  M  to memory addr, low 2 bits always 0.
- mem_wd  out  M  to memory wd.
- mem_rd  in  M  from memory rd (combinational).

Behaviour:
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
  - Reset mid-operation aborts any pending write with no memory write.
- Request capture: on accept, addr, size, unsigned, wdata and we are registered. mem_addr is driven from the registered address with bits [1:0] cleared.
- Lane selection:
  - Byte: lane=addr[1:0].
  - Half: lane=addr[1]. Little-endian: byte k occupies bits [8k+7:8k].
- States:
  - IDLE: req_ready=1. On accept:
    - Load -> LOAD.
    - Word store -> WSTORE.
    - Byte/half store -> RMW_RD.
  - LOAD:
    - req_ready=0.
    - Sample mem_rd and extract the lane; extend per size and unsigned flag.
    - Register into resp_rdata with resp_valid=1 on the next edge -> IDLE.
    - Latency: accept edge + 2 edges to the resp_valid pulse.
  - WSTORE:
    - mem_we=1, mem_wd=wdata for exactly one cycle.
    - resp_valid pulses on the following cycle -> IDLE.
  - RMW_RD:
    - req_ready=0.
    - Latch mem_rd into a merge register -> RMW_WR.
  - RMW_WR:
    - mem_we=1; mem_wd = merge register with the selected lane replaced by wdata[7:0] or wdata[15:0].
    - Other bytes are preserved bit-exact.
    - resp_valid pulses the next cycle -> IDLE.
- Back-to-back operation:
  - A new request may be accepted in the same cycle resp_valid is high (state IDLE).
  - A load issued immediately after a store to the same word returns the new data, because the memory write completed before the LOAD sample.
- Size 3 behaves exactly as size 2.
- mem_we is never high outside WSTORE/RMW_WR.
- Holding req_valid high while req_ready=0 has no effect; inputs are ignored while busy.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- With the macro defined, a request is rejected when any of these holds:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[M-1:2] >= 2**N.
- A rejected request:
  - is accepted normally, goes to a one-cycle ERR state, performs no memory access (mem_we stays 0);
  - pulses resp_valid with resp_err=1 and resp_rdata=0, then returns to IDLE.
- Without the macro: resp_err is tied 0; low address bits are ignored for half (bit 0) and word (bits 1:0), and addresses wrap modulo memory depth.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - the FSM state enum (IDLE, LOAD, WSTORE, RMW_RD, RMW_WR, ERR);
  - the lane-mask helper constant widths.
- One natural sub-module: lsu_lane_mux, purely combinational. It performs lane extract+extend for loads and lane merge for stores, so it can be unit-tested alone.

Test Plan:
1. Memory word 0 = 32'h80FF_7F01.
   - Byte load, addr 1, signed -> resp_rdata=32'h0000_007F.
   - addr 2, signed -> 32'hFFFF_FFFF.
   - addr 3, unsigned -> 32'h0000_0080.
2. Memory word 1 = 32'hCAFE_8001.
   - Half load, addr 4, signed -> 32'hFFFF_8001.
   - addr 6, unsigned -> 32'h0000_CAFE.
3. Memory word 2 = 32'h1122_3344, store byte 8'hAB to addr 9.
   - Exactly one mem_we cycle; word 2 becomes 32'h1122_AB44.
   - resp_valid 3 edges after accept.
4. Word store 32'hDEAD_BEEF to addr 12, immediately followed by a load of addr 12.
   - Load returns 32'hDEAD_BEEF; req_ready drops for exactly one cycle per operation.
5. Assert reset during RMW_RD of a half store to addr 16.
   - mem_we never asserts; word 4 is unchanged.
   - Next cycle: req_ready=1, resp_valid=0.
6. With LSU_ALIGN_CHECK_EN, word store to addr 14 -> resp_err=1, no mem_we.
   - Without the macro, the same store writes word 3 normally.
